// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready handshakes on both sides.
module alu_muldiv #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid_in,
  output logic            start_ready_out,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  output logic            result_valid_out,
  input  logic            result_ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            non_zero_out,
  output logic            illegal_out,
  output logic            busy_out
);

  localparam int              CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [6:0]      OP_M = 7'b0110011;
  localparam logic [6:0]      F7_M = 7'h01;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [2:0]        f3_q, f3_d;
  logic              a_s_q, a_s_d, b_s_q, b_s_d;
  logic              spec_q, spec_d, b_zero_q, b_zero_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;
  logic              ready_q, ready_d;

  // Special divide results: x/0 and the single signed-overflow case.
  function automatic logic [XLEN-1:0] special_res(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] a,
                                                  input logic zero);
    if (zero) return f3[1] ? a : '1;
    else      return f3[1] ? '0 : a;
  endfunction

  // Request decode: which operands are treated as signed, and their magnitudes.
  logic            in_legal, in_signed_a, in_signed_b, in_a_s, in_b_s;
  logic            in_zero, in_ovf, in_special;
  logic [XLEN-1:0] in_abs_a, in_abs_b;

  assign in_legal    = (opcode_in == OP_M) && (funct7 == F7_M);
  assign in_signed_a = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign in_signed_b = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
  assign in_a_s      = in_signed_a & rs1_value_in[XLEN-1];
  assign in_b_s      = in_signed_b & rs2_value_in[XLEN-1];
  assign in_abs_a    = in_a_s ? -rs1_value_in : rs1_value_in;
  assign in_abs_b    = in_b_s ? -rs2_value_in : rs2_value_in;
  assign in_zero     = (rs2_value_in == '0);
  assign in_ovf      = !funct3[0] && (rs1_value_in == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_value_in);
  assign in_special  = in_zero | in_ovf;

  // One multiply step: conditionally add the multiplicand to the high half, shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_full;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  // Unsigned/low-half ops latch both sign flags as 0, so one XOR covers every variant.
  assign mul_full = (a_s_q ^ b_s_q) ? -mul_next : mul_next;
  assign mul_res  = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

  // One restoring-divide step on {remainder, dividend/quotient}.
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_quo, div_rem, div_res;

  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  assign div_quo   = div_next[XLEN-1:0];
  assign div_rem   = div_next[2*XLEN-1:XLEN];
  assign div_res   = f3_q[1] ? (a_s_q ? -div_rem : div_rem)
                             : ((a_s_q ^ b_s_q) ? -div_quo : div_quo);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    f3_d      = f3_q;
    a_s_d     = a_s_q;
    b_s_d     = b_s_q;
    spec_d    = spec_q;
    b_zero_d  = b_zero_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid_in && ready_q) begin
          f3_d      = funct3;
          a_raw_d   = rs1_value_in;
          a_s_d     = in_a_s;
          b_s_d     = in_b_s;
          b_zero_d  = in_zero;
          spec_d    = in_special;
          cnt_d     = '0;
          illegal_d = 1'b0;
          if (!in_legal) begin
            state_d   = S_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
          end else if (funct3[2]) begin
            acc_d  = {{XLEN{1'b0}}, in_abs_a};
            opnd_d = in_abs_b;
            if (EARLY_OUT && in_special) begin
              state_d  = S_DONE;
              result_d = special_res(funct3, rs1_value_in, in_zero);
            end else begin
              state_d = S_DIV;
            end
          end else begin
            acc_d   = {{XLEN{1'b0}}, in_abs_b};
            opnd_d  = in_abs_a;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = spec_q ? special_res(f3_q, a_raw_q, b_zero_q) : div_res;
        end
      end
      S_DONE: begin
        if (result_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered so it reads 0 during the cycle that follows a reset edge.
  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge value of every other register.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      f3_q      <= '0;
      a_s_q     <= 1'b0;
      b_s_q     <= 1'b0;
      spec_q    <= 1'b0;
      b_zero_q  <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      f3_q      <= f3_d;
      a_s_q     <= a_s_d;
      b_s_q     <= b_s_d;
      spec_q    <= spec_d;
      b_zero_q  <= b_zero_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
    end
  end

  assign start_ready_out  = ready_q;
  assign result_valid_out = (state_q == S_DONE);
  assign result_out       = result_q;
  assign non_zero_out     = |result_q;
  assign illegal_out      = illegal_q;
  assign busy_out         = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_alu_muldiv;

  localparam int         XLEN      = 32;
  localparam bit         EARLY_OUT = 1'b1;
  localparam logic [6:0] OP_M      = 7'b0110011;
  localparam logic [6:0] F7_M      = 7'h01;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_valid_in;
  logic            start_ready_out;
  logic [6:0]      opcode_in;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_value_in, rs2_value_in;
  logic            result_valid_out;
  logic            result_ready_in;
  logic [XLEN-1:0] result_out;
  logic            non_zero_out;
  logic            illegal_out;
  logic            busy_out;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.XLEN(XLEN), .EARLY_OUT(EARLY_OUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_valid_in   (start_valid_in),
    .start_ready_out  (start_ready_out),
    .opcode_in        (opcode_in),
    .funct3           (funct3),
    .funct7           (funct7),
    .rs1_value_in     (rs1_value_in),
    .rs2_value_in     (rs2_value_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_out       (result_out),
    .non_zero_out     (non_zero_out),
    .illegal_out      (illegal_out),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = longint'(ua / ub); return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = longint'(ua % ub); return q[31:0];
      end
    endcase
  endfunction

  function automatic int model_latency(input logic legal, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
    logic special;
    if (!legal) return 1;
    special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (special && EARLY_OUT) ? 1 : XLEN + 1;
  endfunction

  // Issue one request, check latency/result/flags, optionally stall, then accept.
  task automatic run_op(input string name, input logic [6:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic        legal;
    logic [31:0] exp_res, held_res;
    logic        held_ill;
    int          exp_lat, lat, w;
    legal   = (op == OP_M) && (f7 == F7_M);
    exp_res = legal ? model(f3, a, b) : 32'h0;
    exp_lat = model_latency(legal, f3, a, b);

    @(negedge clk);
    w = 0;
    while (!start_ready_out && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (start_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: start_ready_out=%b required 1", name, start_ready_out);
    end
    opcode_in = op; funct7 = f7; funct3 = f3;
    rs1_value_in = a; rs2_value_in = b;
    start_valid_in = 1'b1;
    @(posedge clk);
    #1;
    start_valid_in = 1'b0;
    opcode_in = 7'($urandom); funct3 = 3'($urandom);
    rs1_value_in = $urandom; rs2_value_in = $urandom;

    lat = 1;
    while (!result_valid_out && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (result_out !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h required %h (f3=%0d a=%h b=%h)", name, result_out, exp_res, f3, a, b);
    end
    checks++;
    if (non_zero_out !== (exp_res != 0) || illegal_out !== !legal) begin
      errors++;
      $display("FAIL %s flags: nz=%b ill=%b required nz=%b ill=%b", name, non_zero_out, illegal_out,
               exp_res != 0, !legal);
    end

    held_res = result_out;
    held_ill = illegal_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result_out !== held_res || illegal_out !== held_ill || result_valid_out !== 1'b1 ||
          start_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: res=%h ill=%b valid=%b ready=%b required res=%h ill=%b valid=1 ready=0",
                 name, i, result_out, illegal_out, result_valid_out, start_ready_out, held_res, held_ill);
      end
    end

    result_ready_in = 1'b1;
    @(posedge clk);
    #1;
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0 || start_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: valid=%b ready=%b busy=%b required 0 1 0", name, result_valid_out,
               start_ready_out, busy_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_valid_in = 1'b0; result_ready_in = 1'b0;
    opcode_in = OP_M; funct3 = 3'd0; funct7 = F7_M;
    rs1_value_in = '0; rs2_value_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result_valid_out !== 1'b0 || result_out !== 32'h0 || illegal_out !== 1'b0 ||
        busy_out !== 1'b0 || start_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b res=%h ill=%b busy=%b ready=%b required 0 0 0 0 0",
               result_valid_out, result_out, illegal_out, busy_out, start_ready_out);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (start_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: start_ready_out=%b required 1", start_ready_out);
    end
  endtask

  task automatic test_mul();
    run_op("mul_7x-3",      OP_M, F7_M, 3'd0, 32'd7,        32'hFFFF_FFFD, 0);
    run_op("mulhu_ff",      OP_M, F7_M, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh_ff",       OP_M, F7_M, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu_ff_2",   OP_M, F7_M, 3'd2, 32'hFFFF_FFFF, 32'd2,         0);
    run_op("mulh_minmin",   OP_M, F7_M, 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
  endtask

  task automatic test_div();
    run_op("div_-7_2",      OP_M, F7_M, 3'd4, 32'hFFFF_FFF9, 32'd2,  0);
    run_op("rem_-7_2",      OP_M, F7_M, 3'd6, 32'hFFFF_FFF9, 32'd2,  0);
    run_op("divu_100_7",    OP_M, F7_M, 3'd5, 32'd100,       32'd7,  0);
    run_op("remu_100_7",    OP_M, F7_M, 3'd7, 32'd100,       32'd7,  0);
    run_op("rem_7_-2",      OP_M, F7_M, 3'd6, 32'd7,         32'hFFFF_FFFE, 0);
  endtask

  task automatic test_special();
    run_op("divu_5_0",      OP_M, F7_M, 3'd5, 32'd5,         32'd0,  0);
    run_op("rem_5_0",       OP_M, F7_M, 3'd6, 32'd5,         32'd0,  0);
    run_op("div_-5_0",      OP_M, F7_M, 3'd4, 32'hFFFF_FFFB, 32'd0,  0);
    run_op("div_ovf",       OP_M, F7_M, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",       OP_M, F7_M, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_min_ff",   OP_M, F7_M, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_backpressure_illegal();
    run_op("hold_mul",      OP_M,        F7_M,  3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_op("illegal_op",    7'b0010011,  F7_M,  3'd0, 32'd3,         32'd4,         3);
    run_op("illegal_f7",    OP_M,        7'h20, 3'd4, 32'd9,         32'd3,         0);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    opcode_in = OP_M; funct7 = F7_M; funct3 = 3'd4;
    rs1_value_in = 32'd1000; rs2_value_in = 32'd7;
    start_valid_in = 1'b1;
    @(posedge clk);
    #1;
    start_valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b0 || result_out !== 32'h0 || start_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b busy=%b res=%h ready=%b required 0 0 0 0",
               result_valid_out, busy_out, result_out, start_ready_out);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_result: valid cycles=%0d required 0", seen);
    end
    run_op("post_reset_mul", OP_M, F7_M, 3'd0, 32'd3, 32'd4, 0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", OP_M, F7_M, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("b2b_1", OP_M, F7_M, 3'd7, 32'hDEAD_BEEF, 32'h0000_0100, 0);
    run_op("b2b_2", OP_M, F7_M, 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  op;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = 32'h0;
      if (sel == 1) b = 32'hFFFF_FFFF;
      if (sel == 2) a = 32'h8000_0000;
      if (sel == 3) b = b >> 20;
      op = ($urandom_range(0, 15) == 0) ? 7'b0110111 : OP_M;
      run_op("random", op, F7_M, f3, a, b, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure_illegal();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
